efuse_seq_ctrl: RTL and testbench

EFUSE_SEQ_CTRL -- requirements
Module: efuse_seq_ctrl

---
 rtl/efuse_seq_ctrl_if.sv | 29 ++
 rtl/efuse_seq_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_efuse_seq_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/efuse_seq_ctrl_if.sv
// eFuse PHY bus: read/write start pulses, word selects, write data,
// read data and level done strobes. master = controller, slave = PHY.
interface efuse_seq_ctrl_if #(
  parameter int NR  = 64,
  parameter int NW  = 64,
  parameter int RSW = 2,
  parameter int WSW = 2
);
  logic           read_start;
  logic [RSW-1:0] efuse_read_sel;
  logic [NR-1:0]  read_data;
  logic           read_done;
  logic           write_start;
  logic [WSW-1:0] efuse_write_sel;
  logic [NW-1:0]  write_data;
  logic           write_done;

  modport master (
    output read_start, efuse_read_sel,
    output write_start, efuse_write_sel, write_data,
    input  read_data, read_done, write_done
  );

  modport slave (
    input  read_start, efuse_read_sel,
    input  write_start, efuse_write_sel, write_data,
    output read_data, read_done, write_done
  );
endinterface

// File: rtl/efuse_seq_ctrl.sv
// eFuse sequencer: autoload shadow of the whole array plus manual
// password-gated read/write. Ports: clk/rst_n, pmu/rg control, status, phy bus.
module efuse_seq_ctrl #(
  parameter int          NBITS    = 256,
  parameter int          NR       = 64,
  parameter int          NW       = 64,
  parameter logic [15:0] PASSWORD = 16'hA5C3,
  parameter int          TMO      = 1023,
  localparam int RWORDS = NBITS / NR,
  localparam int WWORDS = NBITS / NW,
  localparam int RSW = (RWORDS > 1) ? $clog2(RWORDS) : 1,
  localparam int WSW = (WWORDS > 1) ? $clog2(WWORDS) : 1,
  localparam int TW  = $clog2(TMO + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pmu_efuse_start,
  input  logic [1:0]       rg_efuse_mode,
  input  logic             rg_efuse_start,
  input  logic [RSW-1:0]   rg_efuse_read_sel,
  input  logic [WSW-1:0]   rg_efuse_write_sel,
  input  logic [15:0]      rg_efuse_password,
  input  logic [NW-1:0]    rg_efuse_wdata,
  output logic [NR-1:0]    rg_efuse_rdata,
  output logic             rg_efuse_done,
  output logic [1:0]       rg_efuse_err,
  output logic [NBITS-1:0] efuse_autoload_data,
  output logic             efuse_autoload_vld,
  output logic             efuse_autoload_done,
  output logic             efuse_no_blank,
  output logic             efuse_busy,
  efuse_seq_ctrl_if.master phy
);

  typedef enum logic [2:0] {
    IDLE, AL_RD, AL_WAIT, RD_WAIT, WR_WAIT
  } state_t;

  localparam logic [RSW-1:0] LAST = RSW'(RWORDS - 1);

  state_t           r_state, w_next;
  logic [RSW-1:0]   r_cnt, r_rsel;
  logic [WSW-1:0]   r_wsel;
  logic [NW-1:0]    r_wdata;
  logic [NR-1:0]    r_rdata;
  logic [NBITS-1:0] r_al_data;
  logic [TW-1:0]    r_tmo;
  logic [1:0]       r_err;
  logic r_done, r_al_done, r_vld, r_nb;
  logic r_rd_q, r_wr_q, r_rd_pulse, r_wr_pulse;

  logic w_pmu, w_man, w_mrd, w_mwr, w_mbad;
  logic w_rd_edge, w_wr_edge, w_tmo, w_last;
  logic w_read_start, w_busy;

  assign w_pmu  = (r_state == IDLE) && pmu_efuse_start;
  assign w_man  = (r_state == IDLE) && !pmu_efuse_start &&
                  rg_efuse_start && r_al_done;
  assign w_mrd  = w_man && (rg_efuse_mode == 2'd0);
  assign w_mwr  = w_man && (rg_efuse_mode == 2'd1) &&
                  (rg_efuse_password == PASSWORD);
  assign w_mbad = w_man && !w_mrd && !w_mwr;

  assign w_rd_edge = phy.read_done && !r_rd_q;
  assign w_wr_edge = phy.write_done && !r_wr_q;
  assign w_tmo     = (r_tmo == TW'(TMO));
  assign w_last    = (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_pmu)      w_next = AL_RD;
        else if (w_mrd) w_next = RD_WAIT;
        else if (w_mwr) w_next = WR_WAIT;
      end
      AL_RD: w_next = AL_WAIT;
      AL_WAIT: begin
        if (w_rd_edge) w_next = w_last ? IDLE : AL_RD;
        else if (w_tmo) w_next = IDLE;
      end
      RD_WAIT: if (w_rd_edge || w_tmo) w_next = IDLE;
      WR_WAIT: if (w_wr_edge || w_tmo) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Manual read start is registered so the PHY never sees a
  // combinational path from rg_efuse_start.
  always_comb begin
    w_read_start = r_rd_pulse;
    w_busy       = 1'b1;
    unique case (r_state)
      IDLE:    w_busy = 1'b0;
      AL_RD:   w_read_start = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_rsel     <= '0;
      r_wsel     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_al_data  <= '0;
      r_tmo      <= '0;
      r_err      <= '0;
      r_done     <= 1'b0;
      r_al_done  <= 1'b0;
      r_vld      <= 1'b0;
      r_nb       <= 1'b0;
      r_rd_q     <= 1'b0;
      r_wr_q     <= 1'b0;
      r_rd_pulse <= 1'b0;
      r_wr_pulse <= 1'b0;
    end else begin
      r_rd_q     <= phy.read_done;
      r_wr_q     <= phy.write_done;
      r_vld      <= 1'b0;
      r_rd_pulse <= 1'b0;
      r_wr_pulse <= 1'b0;
      r_tmo      <= (w_busy && r_state != AL_RD) ?
                    r_tmo + TW'(1) : '0;
      if (w_pmu) begin
        r_cnt     <= '0;
        r_rsel    <= '0;
        r_nb      <= 1'b0;
        r_al_done <= 1'b0;
      end
      if (w_man) begin
        r_done <= 1'b0;
        r_err  <= '0;
      end
      if (w_mrd) begin
        r_rsel     <= rg_efuse_read_sel;
        r_rd_pulse <= 1'b1;
      end
      if (w_mwr) begin
        r_wsel     <= rg_efuse_write_sel;
        r_wdata    <= rg_efuse_wdata;
        r_wr_pulse <= 1'b1;
      end
      if (w_mbad) begin
        r_err[0] <= 1'b1;
        r_done   <= 1'b1;
      end
      unique case (r_state)
        AL_WAIT: begin
          if (w_rd_edge) begin
            r_al_data[int'(r_cnt)*NR +: NR] <= phy.read_data;
            r_nb <= r_nb | (|phy.read_data);
            if (!w_last) begin
              r_cnt  <= r_cnt + RSW'(1);
              r_rsel <= r_cnt + RSW'(1);
            end else begin
              r_al_done <= 1'b1;
              r_vld     <= 1'b1;
            end
          end else if (w_tmo) begin
            r_err[1] <= 1'b1;
          end
        end
        RD_WAIT: begin
          if (w_rd_edge) begin
            r_rdata <= phy.read_data;
            r_done  <= 1'b1;
          end else if (w_tmo) begin
            r_err[1] <= 1'b1;
            r_done   <= 1'b1;
          end
        end
        WR_WAIT: begin
          if (w_wr_edge) begin
            r_done <= 1'b1;
          end else if (w_tmo) begin
            r_err[1] <= 1'b1;
            r_done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rg_efuse_rdata      = r_rdata;
  assign rg_efuse_done       = r_done;
  assign rg_efuse_err        = r_err;
  assign efuse_autoload_data = r_al_data;
  assign efuse_autoload_vld  = r_vld;
  assign efuse_autoload_done = r_al_done;
  assign efuse_no_blank      = r_nb;
  assign efuse_busy          = w_busy;
  assign phy.read_start      = w_read_start;
  assign phy.efuse_read_sel  = r_rsel;
  assign phy.write_start     = r_wr_pulse;
  assign phy.efuse_write_sel = r_wsel;
  assign phy.write_data      = r_wdata;

endmodule

// File: tb/tb_efuse_seq_ctrl.sv
// Directed bench for efuse_seq_ctrl with a behavioural PHY that
// answers every start with a done level three cycles later.
module tb_efuse_seq_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pmu_efuse_start = 1'b0;
  logic [1:0]   rg_efuse_mode = 2'd0;
  logic         rg_efuse_start = 1'b0;
  logic [1:0]   rg_efuse_read_sel = 2'd0;
  logic [1:0]   rg_efuse_write_sel = 2'd0;
  logic [15:0]  rg_efuse_password = 16'h0;
  logic [63:0]  rg_efuse_wdata = 64'h0;
  logic [63:0]  rg_efuse_rdata;
  logic         rg_efuse_done;
  logic [1:0]   rg_efuse_err;
  logic [255:0] efuse_autoload_data;
  logic         efuse_autoload_vld;
  logic         efuse_autoload_done;
  logic         efuse_no_blank;
  logic         efuse_busy;

  efuse_seq_ctrl_if #(.NR(64), .NW(64), .RSW(2), .WSW(2)) phy ();

  efuse_seq_ctrl #(.TMO(15)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .pmu_efuse_start     (pmu_efuse_start),
    .rg_efuse_mode       (rg_efuse_mode),
    .rg_efuse_start      (rg_efuse_start),
    .rg_efuse_read_sel   (rg_efuse_read_sel),
    .rg_efuse_write_sel  (rg_efuse_write_sel),
    .rg_efuse_password   (rg_efuse_password),
    .rg_efuse_wdata      (rg_efuse_wdata),
    .rg_efuse_rdata      (rg_efuse_rdata),
    .rg_efuse_done       (rg_efuse_done),
    .rg_efuse_err        (rg_efuse_err),
    .efuse_autoload_data (efuse_autoload_data),
    .efuse_autoload_vld  (efuse_autoload_vld),
    .efuse_autoload_done (efuse_autoload_done),
    .efuse_no_blank      (efuse_no_blank),
    .efuse_busy          (efuse_busy),
    .phy                 (phy)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [4];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          rd_starts = 0;
  int          wr_starts = 0;
  int          vld_cnt = 0;
  bit          rd_en = 1'b1;
  logic [7:0]  sel_hist = 8'h0;
  logic [1:0]  last_wsel = 2'd0;
  logic [63:0] last_wdata = 64'h0;

  // PHY responder, evaluated on the inactive edge
  always @(negedge clk) begin
    if (efuse_autoload_vld) vld_cnt++;
    if (!rst_n) begin
      phy.read_done  = 1'b0;
      phy.write_done = 1'b0;
      phy.read_data  = 64'h0;
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (phy.read_start) begin
        rd_starts++;
        sel_hist = {sel_hist[5:0], phy.efuse_read_sel};
        phy.read_done = 1'b0;
        rd_cnt = 3;
      end else if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0 && rd_en) begin
          phy.read_data = mem[phy.efuse_read_sel];
          phy.read_done = 1'b1;
        end
      end
      if (phy.write_start) begin
        wr_starts++;
        last_wsel  = phy.efuse_write_sel;
        last_wdata = phy.write_data;
        phy.write_done = 1'b0;
        wr_cnt = 3;
      end else if (wr_cnt > 0) begin
        wr_cnt--;
        if (wr_cnt == 0) phy.write_done = 1'b1;
      end
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_pmu();
    @(negedge clk) pmu_efuse_start = 1'b1;
    @(negedge clk) pmu_efuse_start = 1'b0;
  endtask

  task automatic pulse_rg(input logic [1:0] mode);
    rg_efuse_mode = mode;
    @(negedge clk) rg_efuse_start = 1'b1;
    @(negedge clk) rg_efuse_start = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (efuse_busy && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("wait_bound", efuse_busy, 0);
    repeat (2) @(negedge clk);
  endtask

  int v0;
  int r0;

  initial begin
    mem[0] = 64'h1; mem[1] = 64'h0; mem[2] = 64'h0; mem[3] = 64'h8;
    repeat (3) @(negedge clk);
    chk("rst_busy", efuse_busy, 0);
    chk("rst_aldone", efuse_autoload_done, 0);
    chk("rst_data", efuse_autoload_data, 0);
    chk("rst_rdstart", phy.read_start, 0);
    @(negedge clk) rst_n = 1'b1;

    // manual start before any autoload is ignored
    rg_efuse_read_sel = 2'd1;
    pulse_rg(2'd0);
    @(negedge clk);
    chk("early_busy", efuse_busy, 0);
    chk("early_done", rg_efuse_done, 0);
    chk("early_rdst", rd_starts, 0);

    pulse_pmu();
    wait_idle(200);
    chk("al1_starts", rd_starts, 4);
    chk("al1_sels", sel_hist, 8'h1B);
    chk("al1_data", efuse_autoload_data,
        {64'h8, 64'h0, 64'h0, 64'h1});
    chk("al1_vld", vld_cnt, 1);
    chk("al1_nb", efuse_no_blank, 1);
    chk("al1_done", efuse_autoload_done, 1);
    chk("al1_err", rg_efuse_err, 0);

    mem[0] = 64'h0; mem[3] = 64'h0;
    pulse_pmu();
    wait_idle(200);
    chk("al0_nb", efuse_no_blank, 0);
    chk("al0_done", efuse_autoload_done, 1);
    chk("al0_data", efuse_autoload_data, 0);
    chk("al0_vld", vld_cnt, 2);

    mem[2] = 64'hDEAD;
    rg_efuse_read_sel = 2'd2;
    pulse_rg(2'd0);
    wait_idle(100);
    chk("mrd_data", rg_efuse_rdata, 64'hDEAD);
    chk("mrd_done", rg_efuse_done, 1);
    chk("mrd_err", rg_efuse_err, 0);
    chk("mrd_sel", sel_hist[1:0], 2'd2);
    chk("mrd_starts", rd_starts, 9);

    rg_efuse_password  = 16'hA5C3;
    rg_efuse_write_sel = 2'd3;
    rg_efuse_wdata     = 64'h1234_5678_9ABC_DEF0;
    pulse_rg(2'd1);
    wait_idle(100);
    chk("mwr_starts", wr_starts, 1);
    chk("mwr_sel", last_wsel, 2'd3);
    chk("mwr_data", last_wdata, 64'h1234_5678_9ABC_DEF0);
    chk("mwr_done", rg_efuse_done, 1);
    chk("mwr_err", rg_efuse_err, 0);

    rg_efuse_password = 16'h0000;
    pulse_rg(2'd1);
    repeat (6) @(negedge clk);
    chk("badpw_starts", wr_starts, 1);
    chk("badpw_err", rg_efuse_err, 2'b01);
    chk("badpw_done", rg_efuse_done, 1);
    chk("badpw_busy", efuse_busy, 0);

    pulse_rg(2'd2);
    @(negedge clk);
    chk("rsv_err", rg_efuse_err, 2'b01);
    chk("rsv_rdst", rd_starts, 9);

    // timeout: accept edge E0, expire on E16
    rd_en = 1'b0;
    rg_efuse_read_sel = 2'd1;
    rg_efuse_mode = 2'd0;
    @(negedge clk) rg_efuse_start = 1'b1;
    @(negedge clk) rg_efuse_start = 1'b0;
    chk("tmo_clr", rg_efuse_err, 0);
    repeat (15) @(negedge clk);
    chk("tmo_busy15", efuse_busy, 1);
    chk("tmo_err15", rg_efuse_err, 0);
    @(negedge clk);
    chk("tmo_err16", rg_efuse_err, 2'b10);
    chk("tmo_idle", efuse_busy, 0);
    chk("tmo_done", rg_efuse_done, 1);
    rd_en = 1'b1;
    repeat (4) @(negedge clk);

    mem[0] = 64'h1; mem[1] = 64'h0; mem[2] = 64'h0; mem[3] = 64'h8;
    v0 = vld_cnt;
    pulse_pmu();
    repeat (6) @(negedge clk);
    chk("mid_busy", efuse_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("ar_busy", efuse_busy, 0);
    chk("ar_data", efuse_autoload_data, 0);
    chk("ar_err", rg_efuse_err, 0);
    chk("ar_done", rg_efuse_done, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("ar_aldone", efuse_autoload_done, 0);
    chk("ar_novld", vld_cnt, v0);
    r0 = rd_starts;
    pulse_pmu();
    wait_idle(200);
    chk("rl_starts", rd_starts - r0, 4);
    chk("rl_vld", vld_cnt, v0 + 1);
    chk("rl_data", efuse_autoload_data,
        {64'h8, 64'h0, 64'h0, 64'h1});
    chk("rl_done", efuse_autoload_done, 1);
    chk("rl_nb", efuse_no_blank, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
